// File: rtl/qarma128_key_unspec_if.sv
// qarma128_key_unspec_if: key-bus handshake between a specialised-key source and the unspecialisation block
interface qarma128_key_unspec_if;
   logic         in_valid;
   logic         in_ready;
   logic         in_enc;
   logic [127:0] in_w0;
   logic [127:0] in_w1;
   logic [127:0] in_k0;
   logic [127:0] in_k1;
   logic         out_valid;
   logic         out_ready;
   logic [255:0] out_key;
   logic         out_enc;
   logic         out_err;
   modport master (
      output in_valid, in_enc, in_w0, in_w1, in_k0, in_k1, out_ready,
      input  in_ready, out_valid, out_key, out_enc, out_err
   );
   modport slave (
      input  in_valid, in_enc, in_w0, in_w1, in_k0, in_k1, out_ready,
      output in_ready, out_valid, out_key, out_enc, out_err
   );
endinterface

// File: rtl/qarma128_key_unspec.sv
// qarma128_key_unspec: rebuilds the QARMA-128 master key {w,k} from a specialised set; QARMA_KEY_UNSPEC_CHECK_EN adds a consistency check
`ifdef QARMA_KEY_UNSPEC_CHECK_EN
// QARMA-128 MixColumns: circ(0, rho^1, rho^4, rho^5) over 8-bit cells, cell 0 in the top byte, row-major 4x4
module qarma128_mix_columns (
   input  logic [127:0] d,
   output logic [127:0] q
);
   function automatic logic [7:0] rl(input logic [7:0] x, input int n);
      return (x << n) | (x >> (8 - n));
   endfunction
   for (genvar r = 0; r < 4; r++) begin : g_row
      for (genvar c = 0; c < 4; c++) begin : g_col
         assign q[127-8*(4*r+c) -: 8] = rl(d[127-8*(4*((r+1)%4)+c) -: 8], 1)
                                      ^ rl(d[127-8*(4*((r+2)%4)+c) -: 8], 4)
                                      ^ rl(d[127-8*(4*((r+3)%4)+c) -: 8], 5);
      end
   end
endmodule
`endif

module qarma128_key_unspec #(
   parameter int             N     = 128,
   parameter logic [N-1:0]   ALPHA = 128'h243F6A8885A308D313198A2E03707344
) (
   input logic                  clk,
   input logic                  rst,
   qarma128_key_unspec_if.slave bus
);
   typedef enum logic [1:0] {IDLE, RECOV, CHECK, DONE} state_t;
   state_t         state_q, state_d;
   logic           enc_q, enc_d;
   logic [N-1:0]   w0_q, w0_d, w1_q, w1_d, k0_q, k0_d;
   logic [2*N-1:0] out_key_q, out_key_d;
   logic           out_enc_q, out_enc_d;
`ifdef QARMA_KEY_UNSPEC_CHECK_EN
   logic [N-1:0]   k1_q, k1_d, mc_k;
   logic           out_err_q, out_err_d;
   function automatic logic [N-1:0] ortho(input logic [N-1:0] t);
      return {t[0], t[N-1:2], t[1] ^ t[N-1]};
   endfunction
   qarma128_mix_columns u_mc (.d(out_key_q[N-1:0]), .q(mc_k));
   assign bus.out_err = out_err_q;
`else
   logic k1_unused;
   assign k1_unused   = ^bus.in_k1;
   assign bus.out_err = 1'b0;
`endif
   assign bus.in_ready  = state_q == IDLE;
   assign bus.out_valid = state_q == DONE;
   assign bus.out_key   = out_key_q;
   assign bus.out_enc   = out_enc_q;
   // next-state and datapath: capture in IDLE, recover in RECOV, compare in CHECK, hold in DONE
   always_comb begin
      state_d   = state_q;
      enc_d     = enc_q;
      w0_d      = w0_q;
      w1_d      = w1_q;
      k0_d      = k0_q;
      out_key_d = out_key_q;
      out_enc_d = out_enc_q;
`ifdef QARMA_KEY_UNSPEC_CHECK_EN
      k1_d      = k1_q;
      out_err_d = out_err_q;
`endif
      case (state_q)
         IDLE: if (bus.in_valid) begin
            enc_d   = bus.in_enc;
            w0_d    = bus.in_w0;
            w1_d    = bus.in_w1;
            k0_d    = bus.in_k0;
`ifdef QARMA_KEY_UNSPEC_CHECK_EN
            k1_d    = bus.in_k1;
`endif
            state_d = RECOV;
         end
         RECOV: begin
            out_key_d = enc_q ? {w0_q, k0_q} : {w1_q, k0_q ^ ALPHA};
            out_enc_d = enc_q;
`ifdef QARMA_KEY_UNSPEC_CHECK_EN
            out_err_d = 1'b0;
            state_d   = CHECK;
`else
            state_d   = DONE;
`endif
         end
`ifdef QARMA_KEY_UNSPEC_CHECK_EN
         CHECK: begin
            out_err_d = enc_q ? (w1_q != ortho(w0_q)) || (k1_q != k0_q)
                              : (w0_q != ortho(w1_q)) || (k1_q != mc_k);
            state_d   = DONE;
         end
`endif
         DONE: state_d = bus.out_ready ? IDLE : DONE;
         default: state_d = IDLE;
      endcase
   end
   // state and output registers, cleared by synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         enc_q     <= 1'b0;
         w0_q      <= '0;
         w1_q      <= '0;
         k0_q      <= '0;
         out_key_q <= '0;
         out_enc_q <= 1'b0;
`ifdef QARMA_KEY_UNSPEC_CHECK_EN
         k1_q      <= '0;
         out_err_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         enc_q     <= enc_d;
         w0_q      <= w0_d;
         w1_q      <= w1_d;
         k0_q      <= k0_d;
         out_key_q <= out_key_d;
         out_enc_q <= out_enc_d;
`ifdef QARMA_KEY_UNSPEC_CHECK_EN
         k1_q      <= k1_d;
         out_err_q <= out_err_d;
`endif
      end
   end
endmodule

// File: tb/tb_qarma128_key_unspec.sv
// tb_qarma128_key_unspec: directed vectors for qarma128_key_unspec (both QARMA_KEY_UNSPEC_CHECK_EN builds)
module tb_qarma128_key_unspec;
   localparam logic [127:0] ALPHA  = 128'h243F6A8885A308D313198A2E03707344;
   localparam logic [127:0] A5     = {16{8'hA5}};
   localparam logic [127:0] B127   = {1'b1, 127'b0};
   localparam logic [127:0] K_ONE  = 128'h01000000_00000000_00000000_00000000;
   localparam logic [127:0] MC_ONE = 128'h00000000_20000000_10000000_02000000;
`ifdef QARMA_KEY_UNSPEC_CHECK_EN
   localparam int   LAT = 2;
   localparam logic CK  = 1'b1;
`else
   localparam int   LAT = 1;
   localparam logic CK  = 1'b0;
`endif
   logic clk = 1'b0;
   logic rst;
   int   n_vec = 0;
   int   n_err = 0;
   int   lat;
   qarma128_key_unspec_if bus ();
   qarma128_key_unspec dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic enc, input logic [127:0] w0, w1, k0, k1);
      bus.in_enc = enc;
      bus.in_w0  = w0;
      bus.in_w1  = w1;
      bus.in_k0  = k0;
      bus.in_k1  = k1;
   endtask

   task automatic wait_valid(output int l);
      l = 0;
      while (bus.out_valid !== 1'b1 && l < 10) begin
         @(negedge clk);
         l++;
      end
   endtask

   task automatic run(input string tag, input logic enc, input logic [127:0] w0, w1, k0, k1,
                      input logic [255:0] ekey, input logic eenc, input logic eerr);
      int l;
      @(negedge clk);
      drive(enc, w0, w1, k0, k1);
      bus.in_valid = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      wait_valid(l);
      chk({tag, "_lat"}, l, LAT);
      chk({tag, "_key"}, bus.out_key, ekey);
      chk({tag, "_enc"}, bus.out_enc, eenc);
      chk({tag, "_err"}, bus.out_err, eerr);
      @(negedge clk);
      chk({tag, "_idle"}, {bus.out_valid, bus.in_ready}, 2'b01);
   endtask

   initial begin
      rst = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      drive(1'b0, '0, '0, '0, '0);
      @(negedge clk);
      @(negedge clk);
      chk("rst_ready", bus.in_ready, 1'b1);
      chk("rst_valid", bus.out_valid, 1'b0);
      chk("rst_key", bus.out_key, '0);
      chk("rst_enc", bus.out_enc, 1'b0);
      chk("rst_err", bus.out_err, 1'b0);
      rst = 1'b0;
      run("enc_zero", 1'b1, '0, '0, '0, '0, '0, 1'b1, 1'b0);
      run("enc_set", 1'b1, 128'h1, B127, A5, A5, {128'h1, A5}, 1'b1, 1'b0);
      run("enc_bad_w", 1'b1, 128'h1, B127 | 128'h1, A5, A5, {128'h1, A5}, 1'b1, CK);
      run("enc_bad_k", 1'b1, 128'h1, B127, A5, ~A5, {128'h1, A5}, 1'b1, CK);
      run("dec_set", 1'b0, B127, 128'h1, ALPHA, '0, {128'h1, 128'h0}, 1'b0, 1'b0);
      run("dec_bad_k", 1'b0, B127, 128'h1, ALPHA, 128'h1, {128'h1, 128'h0}, 1'b0, CK);
      run("dec_bad_w", 1'b0, 128'h3, 128'h1, ALPHA, '0, {128'h1, 128'h0}, 1'b0, CK);
      run("dec_mc", 1'b0, B127, 128'h1, ALPHA ^ K_ONE, MC_ONE, {128'h1, K_ONE}, 1'b0, 1'b0);
      // back-pressure: DONE holds while a competing set is presented
      bus.out_ready = 1'b0;
      @(negedge clk);
      drive(1'b1, 128'h1, B127, A5, A5);
      bus.in_valid = 1'b1;
      @(negedge clk);
      drive(1'b0, 128'h5, 128'h6, 128'h7, 128'h8);
      wait_valid(lat);
      chk("bp_lat", lat, LAT);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_valid", bus.out_valid, 1'b1);
         chk("bp_ready", bus.in_ready, 1'b0);
         chk("bp_key", bus.out_key, {128'h1, A5});
         chk("bp_enc", bus.out_enc, 1'b1);
         chk("bp_err", bus.out_err, 1'b0);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("bp_release", {bus.out_valid, bus.in_ready}, 2'b01);
      @(negedge clk);
      chk("bp_no_accept", {bus.out_valid, bus.in_ready}, 2'b01);
      // reset while a set is in RECOV discards it and clears the previous key
      drive(1'b0, B127, 128'h1, ALPHA, '0);
      bus.in_valid = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_rst_valid", bus.out_valid, 1'b0);
      chk("mid_rst_key", bus.out_key, '0);
      chk("mid_rst_err", bus.out_err, 1'b0);
      chk("mid_rst_ready", bus.in_ready, 1'b1);
      run("post_rst", 1'b1, 128'h1, B127, A5, A5, {128'h1, A5}, 1'b1, 1'b0);
      // back-to-back with in_valid held high
      @(negedge clk);
      drive(1'b1, 128'h1, B127, A5, A5);
      bus.in_valid = 1'b1;
      @(negedge clk);
      drive(1'b0, B127, 128'h1, ALPHA, '0);
      wait_valid(lat);
      chk("b2b_a_lat", lat, LAT);
      chk("b2b_a_key", bus.out_key, {128'h1, A5});
      chk("b2b_a_enc", bus.out_enc, 1'b1);
      @(negedge clk);
      chk("b2b_gap", {bus.out_valid, bus.in_ready}, 2'b01);
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk("b2b_b_taken", bus.in_ready, 1'b0);
      wait_valid(lat);
      chk("b2b_b_lat", lat, LAT);
      chk("b2b_b_key", bus.out_key, {128'h1, 128'h0});
      chk("b2b_b_enc", bus.out_enc, 1'b0);
      @(negedge clk);
      chk("b2b_end", {bus.out_valid, bus.in_ready}, 2'b01);
      @(negedge clk);
      @(negedge clk);
      chk("b2b_no_dup", {bus.out_valid, bus.in_ready}, 2'b01);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
